// File: rtl/hazard_controller.sv
// Pipeline hazard controller: 3-slot EX/MEM/WB scoreboard, operand forwarding, load-use stall
// and branch flush sequencing. Optional HAZARD_PERF_EN adds saturating stall/flush counters.
module hazard_controller #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned REG_ADDR_W   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
    input  logic                  id_writeback_i,
    input  logic                  id_is_load_i,
    input  logic                  branch_taken_i,
    output logic                  issue_o,
    output logic                  stall_o,
    output logic                  flush_o,
    output logic [1:0]            rs1_fwd_sel_o,
    output logic [1:0]            rs2_fwd_sel_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           stall_count_o,
    output logic [31:0]           flush_count_o
`endif
);

    localparam logic [1:0] StRun       = 2'd0;
    localparam logic [1:0] StLoadStall = 2'd1;
    localparam logic [1:0] StFlush     = 2'd2;

    localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES);

    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic                  ex_valid_q, ex_wb_q, ex_load_q;
    logic                  mem_valid_q, mem_wb_q, mem_load_q;
    logic                  wb_valid_q, wb_wb_q, wb_load_q;
    logic [REG_ADDR_W-1:0] ex_rd_q, mem_rd_q, wb_rd_q;

    logic issue, stall, flush, load_use;
    logic ex_hit1, ex_hit2, mem_hit1, mem_hit2, wb_hit1, wb_hit2;
    logic [1:0] sel1, sel2;

    function automatic logic slot_hit(input logic v, input logic wb, input logic [REG_ADDR_W-1:0] rd,
                                      input logic [REG_ADDR_W-1:0] src, input logic used);
        return v && wb && (rd != '0) && (rd == src) && used;
    endfunction

    always_comb begin
        ex_hit1  = slot_hit(ex_valid_q, ex_wb_q, ex_rd_q, id_rs1_addr_i, id_rs1_used_i);
        ex_hit2  = slot_hit(ex_valid_q, ex_wb_q, ex_rd_q, id_rs2_addr_i, id_rs2_used_i);
        mem_hit1 = slot_hit(mem_valid_q, mem_wb_q, mem_rd_q, id_rs1_addr_i, id_rs1_used_i);
        mem_hit2 = slot_hit(mem_valid_q, mem_wb_q, mem_rd_q, id_rs2_addr_i, id_rs2_used_i);
        wb_hit1  = slot_hit(wb_valid_q, wb_wb_q, wb_rd_q, id_rs1_addr_i, id_rs1_used_i);
        wb_hit2  = slot_hit(wb_valid_q, wb_wb_q, wb_rd_q, id_rs2_addr_i, id_rs2_used_i);

        sel1 = ex_hit1 ? 2'd1 : mem_hit1 ? 2'd2 : wb_hit1 ? 2'd3 : 2'd0;
        sel2 = ex_hit2 ? 2'd1 : mem_hit2 ? 2'd2 : wb_hit2 ? 2'd3 : 2'd0;

        load_use = id_valid_i && ex_load_q && (ex_hit1 || ex_hit2);
    end

    // The bubble goes in on the load-use cycle itself; LOAD_STALL then lets the dependent
    // instruction issue with the load forwarded from MEM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        issue   = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        if (branch_taken_i) begin
            flush   = 1'b1;
            cnt_d   = FlushLoad;
            state_d = (FLUSH_CYCLES > 1) ? StFlush : StRun;
        end else if (state_q == StFlush) begin
            flush = 1'b1;
            cnt_d = cnt_q - 3'd1;
            if (cnt_q <= 3'd2) begin
                state_d = StRun;
                cnt_d   = 3'd0;
            end
        end else if (load_use) begin
            stall   = 1'b1;
            state_d = StLoadStall;
        end else begin
            issue   = id_valid_i;
            state_d = StRun;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            cnt_q       <= 3'd0;
            ex_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            wb_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ex_valid_q  <= issue;
            mem_valid_q <= ex_valid_q;
            wb_valid_q  <= mem_valid_q;
        end
    end

    // Payload fields are don't-care while the matching valid bit is low.
    always_ff @(posedge clk) begin
        ex_rd_q    <= id_rd_addr_i;
        ex_wb_q    <= id_writeback_i;
        ex_load_q  <= id_is_load_i;
        mem_rd_q   <= ex_rd_q;
        mem_wb_q   <= ex_wb_q;
        mem_load_q <= ex_load_q;
        wb_rd_q    <= mem_rd_q;
        wb_wb_q    <= mem_wb_q;
        wb_load_q  <= mem_load_q;
    end

    assign issue_o       = issue && !rst;
    assign stall_o       = stall && !rst;
    assign flush_o       = flush && !rst;
    assign rs1_fwd_sel_o = rst ? 2'd0 : sel1;
    assign rs2_fwd_sel_o = rst ? 2'd0 : sel2;

    logic unused_wb_load;
    assign unused_wb_load = wb_load_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_o && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_o && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_count_o = stall_cnt_q;
    assign flush_count_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: forwarding distances, load-use, branch flush, reset.
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, rs1_used, rs2_used, writeback, is_load, branch_taken;
    logic [4:0] rs1_addr, rs2_addr, rd_addr;
    logic       issue, stall, flush;
    logic [1:0] rs1_sel, rs2_sel;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_count, flush_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_controller #(.FLUSH_CYCLES(2), .REG_ADDR_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid_i     (id_valid),
        .id_rs1_addr_i  (rs1_addr),
        .id_rs2_addr_i  (rs2_addr),
        .id_rs1_used_i  (rs1_used),
        .id_rs2_used_i  (rs2_used),
        .id_rd_addr_i   (rd_addr),
        .id_writeback_i (writeback),
        .id_is_load_i   (is_load),
        .branch_taken_i (branch_taken),
        .issue_o        (issue),
        .stall_o        (stall),
        .flush_o        (flush),
        .rs1_fwd_sel_o  (rs1_sel),
        .rs2_fwd_sel_o  (rs2_sel)
`ifdef HAZARD_PERF_EN
        ,
        .stall_count_o  (stall_count),
        .flush_count_o  (flush_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 ns after inputs change at the falling edge.
    task automatic step(input logic r, input logic v, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                        input logic wb, input logic ld, input logic br);
        @(negedge clk);
        rst = r; id_valid = v; rs1_addr = r1; rs1_used = u1; rs2_addr = r2; rs2_used = u2;
        rd_addr = rd; writeback = wb; is_load = ld; branch_taken = br;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic i, input logic s, input logic f,
                              input logic [1:0] s1, input logic [1:0] s2);
        chk({tag, ".issue"}, 32'(issue), 32'(i));
        chk({tag, ".stall"}, 32'(stall), 32'(s));
        chk({tag, ".flush"}, 32'(flush), 32'(f));
        chk({tag, ".rs1_sel"}, 32'(rs1_sel), 32'(s1));
        chk({tag, ".rs2_sel"}, 32'(rs2_sel), 32'(s2));
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
        rs1_used = 1'b0; rs2_used = 1'b0; writeback = 1'b0; is_load = 1'b0; branch_taken = 1'b0;

        // Reset with a live instruction on the ID inputs
        step(1, 1, 5'd5, 1, 5'd6, 1, 5'd7, 1, 0, 0);
        expect_out("rst0", 0, 0, 0, 0, 0);
        step(1, 1, 5'd5, 1, 5'd6, 1, 5'd7, 1, 0, 1);
        expect_out("rst1", 0, 0, 0, 0, 0);

        // Forwarding distance 1/2/3 and x0
        step(0, 1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 0, 0);
        expect_out("A", 1, 0, 0, 0, 0);
        step(0, 1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0);
        expect_out("B_ex", 1, 0, 0, 1, 0);
        step(0, 1, 5'd5, 1, 5'd0, 0, 5'd0, 1, 0, 0);
        expect_out("C_mem", 1, 0, 0, 2, 0);
        step(0, 1, 5'd5, 1, 5'd0, 1, 5'd0, 1, 0, 0);
        expect_out("D_wb_x0", 1, 0, 0, 3, 0);
        step(0, 1, 5'd0, 1, 5'd6, 1, 5'd0, 0, 0, 0);
        expect_out("E", 1, 0, 0, 0, 3);

        // Load-use on rs2 then independent after a load
        step(0, 1, 5'd2, 1, 5'd0, 0, 5'd7, 1, 1, 0);
        expect_out("F_ld", 1, 0, 0, 0, 0);
        step(0, 1, 5'd3, 1, 5'd7, 1, 5'd8, 1, 0, 0);
        expect_out("G_lu", 0, 1, 0, 0, 1);
        step(0, 1, 5'd3, 1, 5'd7, 1, 5'd8, 1, 0, 0);
        expect_out("H_fwd", 1, 0, 0, 0, 2);
`ifdef HAZARD_PERF_EN
        chk("H.stall_count", stall_count, 32'd1);
`endif
        step(0, 1, 5'd8, 1, 5'd0, 0, 5'd9, 1, 1, 0);
        expect_out("I_ld", 1, 0, 0, 1, 0);
        step(0, 1, 5'd1, 1, 5'd2, 1, 5'd10, 1, 0, 0);
        expect_out("J_indep", 1, 0, 0, 0, 0);

        // Branch flush, two cycles
        step(0, 1, 5'd10, 1, 5'd9, 1, 5'd0, 0, 0, 1);
        expect_out("K_br", 0, 0, 1, 1, 2);
        step(0, 1, 5'd10, 1, 5'd9, 1, 5'd0, 0, 0, 0);
        expect_out("L_fl2", 0, 0, 1, 2, 3);
        step(0, 1, 5'd10, 1, 5'd0, 0, 5'd11, 1, 0, 0);
        expect_out("M_run", 1, 0, 0, 3, 0);
`ifdef HAZARD_PERF_EN
        chk("M.flush_count", flush_count, 32'd2);
`endif

        // Re-branch during the second flush cycle
        step(0, 1, 5'd11, 1, 5'd0, 0, 5'd0, 0, 0, 1);
        expect_out("N_br", 0, 0, 1, 1, 0);
        step(0, 1, 5'd11, 1, 5'd0, 0, 5'd0, 0, 0, 1);
        expect_out("O_rebr", 0, 0, 1, 2, 0);
        step(0, 1, 5'd11, 1, 5'd0, 0, 5'd0, 0, 0, 0);
        expect_out("P_fl", 0, 0, 1, 3, 0);
        step(0, 1, 5'd0, 0, 5'd0, 0, 5'd12, 1, 1, 0);
        expect_out("Q_run_ld", 1, 0, 0, 0, 0);

        // Load-use coincident with branch: flush wins
        step(0, 1, 5'd12, 1, 5'd0, 0, 5'd0, 0, 0, 1);
        expect_out("R_lu_br", 0, 0, 1, 1, 0);
        step(0, 1, 5'd12, 1, 5'd0, 0, 5'd0, 0, 0, 0);
        expect_out("S_fl", 0, 0, 1, 2, 0);
        step(0, 1, 5'd12, 1, 5'd0, 0, 5'd0, 0, 0, 0);
        expect_out("T_run", 1, 0, 0, 3, 0);

        // Reset while in LOAD_STALL
        step(0, 1, 5'd0, 0, 5'd0, 0, 5'd13, 1, 1, 0);
        expect_out("U_ld", 1, 0, 0, 0, 0);
        step(0, 1, 5'd13, 1, 5'd13, 1, 5'd14, 1, 0, 0);
        expect_out("V_lu", 0, 1, 0, 1, 1);
        step(1, 1, 5'd13, 1, 5'd13, 1, 5'd14, 1, 0, 0);
        expect_out("W_rst", 0, 0, 0, 0, 0);
        step(0, 1, 5'd13, 1, 5'd13, 1, 5'd14, 1, 0, 0);
        expect_out("X_post", 1, 0, 0, 0, 0);
`ifdef HAZARD_PERF_EN
        chk("X.stall_count", stall_count, 32'd0);
        chk("X.flush_count", flush_count, 32'd0);
`endif
        step(0, 1, 5'd14, 1, 5'd0, 0, 5'd0, 0, 0, 0);
        expect_out("Y_ex", 1, 0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
